// File: rtl/mtr_pkg.sv
// mtr_pkg: shared types, default timing constants and the speed-to-duty
// mapping used by both H-bridge sides of mtr_drv.
package mtr_pkg;

  localparam int PWM_W = 11;

  typedef logic [PWM_W-1:0] duty_t;

  localparam int DEAD_CYC_DEF  = 64;
  localparam int BLANK_CYC_DEF = 32;
  localparam int FAULT_LIM_DEF = 4;

  // Magnitude of a signed 12-bit speed; -2048 has no 11-bit magnitude and
  // saturates to full scale.
  function automatic duty_t spd2duty(input logic signed [11:0] spd);
    logic [11:0] mag;
    mag = '0;
    if (!spd[11]) return spd[10:0];
    mag = -spd;
    if (mag[11]) return '1;
    return mag[10:0];
  endfunction

endpackage

// File: rtl/mtr_side.sv
// mtr_side: one H-bridge channel. Shadow duty/direction, reversal dead
// time, output routing and, with MTR_OVR_I_EN defined, the over-current
// synchronizer, blanked trip detection and consecutive-fault counter.
module mtr_side
  import mtr_pkg::*;
#(
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int FAULT_LIM = FAULT_LIM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  duty_t              cnt,
  input  logic               load,
  input  logic signed [11:0] spd,
  input  logic               ovr,
  input  logic               shtdwn,
  output logic               pwm1,
  output logic               pwm2,
  output logic               fault_lim
);

  duty_t       duty_sh;
  logic        dir_sh;
  logic [15:0] dead_cnt;
  logic        raw_d;
  logic        force_low;

  assign raw_d = (cnt < duty_sh);

  // Shadow registers only change at the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh <= '0;
      dir_sh  <= 1'b1;
    end else if (load) begin
      duty_sh <= spd2duty(spd);
      dir_sh  <= ~spd[11];
    end
  end

  // Dead counter restarts on a direction reversal, otherwise runs down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dead_cnt <= '0;
    end else if (load && (~spd[11] != dir_sh)) begin
      dead_cnt <= 16'(DEAD_CYC);
    end else if (dead_cnt != '0) begin
      dead_cnt <= dead_cnt - 1'b1;
    end
  end

`ifdef MTR_OVR_I_EN
  logic [1:0] sync;
  logic       pwm_raw;
  logic       tripped;
  logic       trip_now;
  logic [7:0] fcnt;
  logic [7:0] fcnt_nxt;

  // Two-flop synchronizer for the asynchronous comparator input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], ovr};
  end

  // Undelayed raw PWM, used only to qualify trips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_raw <= 1'b0;
    else     pwm_raw <= raw_d;
  end

  assign trip_now = sync[1] & pwm_raw & (cnt >= duty_t'(BLANK_CYC));

  // Trip latch holds the side off until the next period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tripped <= 1'b0;
    else if (load)     tripped <= 1'b0;
    else if (trip_now) tripped <= 1'b1;
  end

  // Consecutive tripped periods, evaluated at each boundary.
  always_comb begin
    fcnt_nxt = fcnt;
    if (load) begin
      if (tripped | trip_now) begin
        if (fcnt < 8'(FAULT_LIM)) fcnt_nxt = fcnt + 1'b1;
      end else begin
        fcnt_nxt = '0;
      end
    end
  end

  // Fault counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt <= '0;
    else     fcnt <= fcnt_nxt;
  end

  assign fault_lim = (fcnt_nxt == 8'(FAULT_LIM));
  assign force_low = (dead_cnt != '0) | tripped | trip_now | shtdwn;
`else
  localparam int unused_cfg = BLANK_CYC + FAULT_LIM;
  logic unused_ovr;
  assign unused_ovr = ovr;
  assign fault_lim  = 1'b0;
  assign force_low  = (dead_cnt != '0) | shtdwn;
`endif

  // Registered drive; direction selects the leg so both are never high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm1 <= 1'b0;
      pwm2 <= 1'b0;
    end else begin
      pwm1 <= raw_d &  dir_sh & ~force_low;
      pwm2 <= raw_d & ~dir_sh & ~force_low;
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM driver. Shared 11-bit period counter, two
// mtr_side channels, and (with MTR_OVR_I_EN defined) a sticky over-current
// shutdown latch fed by either side's fault-limit flag.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int FAULT_LIM = FAULT_LIM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               lft_PWM1,
  output logic               lft_PWM2,
  output logic               rght_PWM1,
  output logic               rght_PWM2,
  output logic               OVR_I_shtdwn
);

  duty_t cnt;
  logic  load;
  logic  lim_l;
  logic  lim_r;

  assign load = (cnt == '1);

  // Free-running period counter; the 2047->0 edge is the load edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

`ifdef MTR_OVR_I_EN
  logic shtdwn_q;

  // Shutdown is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               shtdwn_q <= 1'b0;
    else if (lim_l | lim_r) shtdwn_q <= 1'b1;
  end

  assign OVR_I_shtdwn = shtdwn_q;
`else
  logic unused_lim;
  assign unused_lim   = lim_l | lim_r;
  assign OVR_I_shtdwn = 1'b0;
`endif

  mtr_side #(
    .DEAD_CYC (DEAD_CYC),
    .BLANK_CYC(BLANK_CYC),
    .FAULT_LIM(FAULT_LIM)
  ) u_lft (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .load     (load),
    .spd      (lft_spd),
    .ovr      (OVR_I_lft),
    .shtdwn   (OVR_I_shtdwn),
    .pwm1     (lft_PWM1),
    .pwm2     (lft_PWM2),
    .fault_lim(lim_l)
  );

  mtr_side #(
    .DEAD_CYC (DEAD_CYC),
    .BLANK_CYC(BLANK_CYC),
    .FAULT_LIM(FAULT_LIM)
  ) u_rght (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .load     (load),
    .spd      (rght_spd),
    .ovr      (OVR_I_rght),
    .shtdwn   (OVR_I_shtdwn),
    .pwm1     (rght_PWM1),
    .pwm2     (rght_PWM2),
    .fault_lim(lim_r)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: per-period scoreboard for mtr_drv. Each table row describes
// one PWM period; the driver pushes the row's expected high-counts when the
// period starts and the monitor compares them when the period ends.
module tb_mtr_drv;

`ifdef MTR_OVR_I_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] lft_spd, rght_spd;
  logic               OVR_I_lft, OVR_I_rght;
  logic               lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, OVR_I_shtdwn;

  always #5 clk = ~clk;

  mtr_drv dut (
    .clk         (clk),
    .rst         (rst),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .OVR_I_lft   (OVR_I_lft),
    .OVR_I_rght  (OVR_I_rght),
    .lft_PWM1    (lft_PWM1),
    .lft_PWM2    (lft_PWM2),
    .rght_PWM1   (rght_PWM1),
    .rght_PWM2   (rght_PWM2),
    .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  typedef struct {
    int ls, rs, lo, ro;
    int l1, l2, r1, r2, lf, rf, sd;
  } row_t;

  typedef struct {
    int l1, l2, r1, r2, lf, rf, sd;
  } exp_t;

  localparam int NROW = 20;
  row_t rows[NROW];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [10:0] tb_cnt;

  function automatic row_t mk(int ls, int rs, int lo, int ro, int l1, int l2,
                              int r1, int r2, int lf, int rf, int sd);
    row_t r;
    r.ls = ls; r.rs = rs; r.lo = lo; r.ro = ro;
    r.l1 = l1; r.l2 = l2; r.r1 = r1; r.r2 = r2;
    r.lf = lf; r.rf = rf; r.sd = sd;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Bench copy of the period counter.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 1'b1;
  end

  // Monitor: accumulate one period (cnt 1..2047, 0) and compare at its end.
  initial begin
    int   c_l1, c_l2, c_r1, c_r2, f_l, f_r, ovl;
    bit   active;
    exp_t e;
    active = 0;
    c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; f_l = -1; f_r = -1; ovl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else begin
        if (tb_cnt == 11'd1) begin
          active = 1;
          c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; f_l = -1; f_r = -1; ovl = 0;
        end
        if (active) begin
          c_l1 += int'(lft_PWM1);  c_l2 += int'(lft_PWM2);
          c_r1 += int'(rght_PWM1); c_r2 += int'(rght_PWM2);
          if ((lft_PWM1 | lft_PWM2) && f_l < 0)   f_l = int'(tb_cnt);
          if ((rght_PWM1 | rght_PWM2) && f_r < 0) f_r = int'(tb_cnt);
          if ((lft_PWM1 & lft_PWM2) | (rght_PWM1 & rght_PWM2)) ovl++;
          if (tb_cnt == 11'd0) begin
            active = 0;
            if (q.size() == 0) begin
              chk("no_expected_for_period", 1, 0);
            end else begin
              e = q.pop_front();
              chk("lft_PWM1_high", c_l1, e.l1);
              chk("lft_PWM2_high", c_l2, e.l2);
              chk("rght_PWM1_high", c_r1, e.r1);
              chk("rght_PWM2_high", c_r2, e.r2);
              chk("lft_first_high", f_l, e.lf);
              chk("rght_first_high", f_r, e.rf);
              chk("shtdwn_at_boundary", int'(OVR_I_shtdwn), e.sd);
              chk("leg_overlap", ovl, 0);
            end
          end
        end
      end
    end
  end

  // Drive one period per row; the next row's speeds go in mid-period.
  task automatic run_rows(input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      e.l1 = rows[i].l1; e.l2 = rows[i].l2; e.r1 = rows[i].r1; e.r2 = rows[i].r2;
      e.lf = rows[i].lf; e.rf = rows[i].rf; e.sd = rows[i].sd;
      q.push_back(e);
      for (int c = 1; c <= 2048; c++) begin
        OVR_I_lft  = (c == rows[i].lo);
        OVR_I_rght = (c == rows[i].ro);
        if (c == 1000 && i + 1 < NROW) begin
          lft_spd  = 12'(rows[i+1].ls);
          rght_spd = 12'(rows[i+1].rs);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            ls    rs    lo   ro   l1              l2   r1             r2    lf          rf          sd
    rows[0]  = mk(0,    0,    -1,  -1,  0,              0,   0,             0,    -1,         -1,         0);
    rows[1]  = mk(512,  -2048,-1,  -1,  512,            0,   0,             1983, 1,          65,         0);
    rows[2]  = mk(512,  0,    -1,  -1,  512,            0,   0,             0,    1,          -1,         0);
    rows[3]  = mk(300,  0,    -1,  -1,  300,            0,   0,             0,    1,          -1,         0);
    rows[4]  = mk(-300, 0,    -1,  -1,  0,              236, 0,             0,    65,         -1,         0);
    rows[5]  = mk(1000, 0,    -1,  -1,  936,            0,   0,             0,    65,         -1,         0);
    rows[6]  = mk(1000, 0,    10,  -1,  1000,           0,   0,             0,    1,          -1,         0);
    rows[7]  = mk(1000, 0,    200, -1,  E ? 202 : 1000, 0,   0,             0,    1,          -1,         0);
    rows[8]  = mk(1000, 0,    -1,  -1,  1000,           0,   0,             0,    1,          -1,         0);
    rows[9]  = mk(1000, 700,  -1,  100, 1000,           0,   E ? 102 : 700, 0,    1,          1,          0);
    rows[10] = rows[9];
    rows[11] = rows[9];
    rows[12] = mk(1000, 700,  -1,  -1,  1000,           0,   700,           0,    1,          1,          0);
    rows[13] = rows[9];
    rows[14] = rows[9];
    rows[15] = rows[9];
    rows[16] = mk(1000, 700,  -1,  100, 1000,           0,   E ? 102 : 700, 0,    1,          1,          E ? 1 : 0);
    rows[17] = mk(1000, 700,  -1,  -1,  E ? 0 : 1000,   0,   E ? 0 : 700,   0,    E ? -1 : 1, E ? -1 : 1, E ? 1 : 0);
    rows[18] = mk(1000, 700,  -1,  -1,  0,              0,   0,             0,    -1,         -1,         0);
    rows[19] = mk(1000, 700,  -1,  -1,  1000,           0,   700,           0,    1,          1,          0);

    rst = 1'b1;
    lft_spd = '0; rght_spd = '0;
    OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_lft_PWM1", int'(lft_PWM1), 0);
    chk("reset_rght_PWM2", int'(rght_PWM2), 0);
    chk("reset_shtdwn", int'(OVR_I_shtdwn), 0);
    rst = 1'b0;
    @(negedge clk);
    run_rows(0, 17);

    // Now at cnt=1 of the next period; reset mid-pulse at cnt=300.
    repeat (299) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_lft_PWM1", int'(lft_PWM1), 0);
    chk("midrst_lft_PWM2", int'(lft_PWM2), 0);
    chk("midrst_rght_PWM1", int'(rght_PWM1), 0);
    chk("midrst_rght_PWM2", int'(rght_PWM2), 0);
    chk("midrst_shtdwn", int'(OVR_I_shtdwn), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_rows(18, 19);

    @(negedge clk);
    chk("leftover_expected", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
